// File: rtl/ad_wave_capture.sv
// ad_wave_capture: triggered capture engine for the AD9280 ADC path.
// Generates the ADC clock (clk/2), waits in ARMED for a rising crossing of
// trig_level, then records 2^DEPTH_LOG2 samples into an inferred RAM that is
// read back through a registered port.
// Optional feature macro: AD_CAP_TIMEOUT_EN (forced trigger after TIMEOUT_SMP
// armed samples). Undefined by default: ARMED waits indefinitely, forced=0.
module ad_wave_capture #(
    parameter int unsigned DEPTH_LOG2  = 8,
    parameter int unsigned TIMEOUT_SMP = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  ad_clk,
    input  logic [7:0]            ad_data,
    input  logic                  ad_otr,
    input  logic                  arm,
    input  logic [7:0]            trig_level,
    output logic                  busy,
    output logic                  done,
    output logic                  otr_seen,
    output logic                  forced,
    input  logic [DEPTH_LOG2-1:0] rd_addr,
    output logic [7:0]            rd_data
);

    localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARMED,
        S_CAPTURE,
        S_DONE
    } state_t;

    state_t                state_q, state_d;
    logic                  ad_clk_q, ad_clk_d;
    logic [7:0]            level_q, level_d;
    logic [7:0]            prev_q, prev_d;
    logic                  prev_valid_q, prev_valid_d;
    logic [DEPTH_LOG2-1:0] wptr_q, wptr_d;
    logic                  otr_seen_q, otr_seen_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic [7:0]            rd_data_q;

    logic                  smp;
    logic                  hit;
    logic                  force_trig;
    logic                  we;
    logic [DEPTH_LOG2-1:0] waddr;

    logic [7:0]            mem_q [DEPTH];

`ifdef AD_CAP_TIMEOUT_EN
    localparam int unsigned TMO_W = $clog2(TIMEOUT_SMP + 1);
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic [TMO_W-1:0] tmo_inc;
    logic             forced_q, forced_d;
`endif

    // Sample strobe: the cycle in which ad_clk is high; the edge ending it
    // drives ad_clk low, mid data-valid window.
    assign smp = ad_clk_q;

    // Next-state and datapath control for the capture FSM.
    always_comb begin
        ad_clk_d     = ~ad_clk_q;
        state_d      = state_q;
        level_d      = level_q;
        prev_d       = prev_q;
        prev_valid_d = prev_valid_q;
        wptr_d       = wptr_q;
        otr_seen_d   = otr_seen_q;
        hit          = 1'b0;
        force_trig   = 1'b0;
        we           = 1'b0;
        waddr        = wptr_q;
`ifdef AD_CAP_TIMEOUT_EN
        tmo_d        = tmo_q;
        forced_d     = forced_q;
        tmo_inc      = (tmo_q == '1) ? tmo_q : tmo_q + 1'b1;
`endif
        case (state_q)
            S_IDLE, S_DONE: begin
                if (arm) begin
                    state_d      = S_ARMED;
                    level_d      = trig_level;
                    prev_valid_d = 1'b0;
                    otr_seen_d   = 1'b0;
`ifdef AD_CAP_TIMEOUT_EN
                    tmo_d        = '0;
                    forced_d     = 1'b0;
`endif
                end
            end
            S_ARMED: begin
                if (smp) begin
                    hit = prev_valid_q && (prev_q < level_q) && (ad_data >= level_q);
`ifdef AD_CAP_TIMEOUT_EN
                    tmo_d      = tmo_inc;
                    force_trig = !hit && (tmo_inc == TMO_W'(TIMEOUT_SMP));
                    if (force_trig) begin
                        forced_d = 1'b1;
                    end
`endif
                    if (hit || force_trig) begin
                        we         = 1'b1;
                        waddr      = '0;
                        wptr_d     = DEPTH_LOG2'(1);
                        otr_seen_d = otr_seen_q | ad_otr;
                        state_d    = S_CAPTURE;
                    end else begin
                        prev_d       = ad_data;
                        prev_valid_d = 1'b1;
                    end
                end
            end
            S_CAPTURE: begin
                if (smp) begin
                    we         = 1'b1;
                    wptr_d     = wptr_q + 1'b1;
                    otr_seen_d = otr_seen_q | ad_otr;
                    if (wptr_q == '1) begin
                        state_d = S_DONE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_q == S_ARMED) || (state_q == S_CAPTURE);
        done_d = (state_q == S_DONE);
    end

    // Capture FSM and registered status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            ad_clk_q     <= 1'b0;
            level_q      <= '0;
            prev_q       <= '0;
            prev_valid_q <= 1'b0;
            wptr_q       <= '0;
            otr_seen_q   <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            ad_clk_q     <= ad_clk_d;
            level_q      <= level_d;
            prev_q       <= prev_d;
            prev_valid_q <= prev_valid_d;
            wptr_q       <= wptr_d;
            otr_seen_q   <= otr_seen_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

`ifdef AD_CAP_TIMEOUT_EN
    // Timeout counter and forced flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_q    <= '0;
            forced_q <= 1'b0;
        end else begin
            tmo_q    <= tmo_d;
            forced_q <= forced_d;
        end
    end

    assign forced = forced_q;
`else
    assign forced = 1'b0;
`endif

    // Record buffer write port; contents are intentionally not reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= ad_data;
        end
    end

    // Registered read port, active in every state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= mem_q[rd_addr];
        end
    end

    assign ad_clk   = ad_clk_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign otr_seen = otr_seen_q;
    assign rd_data  = rd_data_q;

endmodule

// File: tb/tb_ad_wave_capture.sv
// Testbench for ad_wave_capture: drives ramp/constant ADC data, predicts the
// trigger point and record contents, and compares through a scoreboard queue.
module tb_ad_wave_capture;

    localparam int unsigned DL2 = 8;
    localparam int unsigned NREC = 256;
    localparam int unsigned TMO = 16;
`ifdef AD_CAP_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst;
    logic           ad_clk;
    logic [7:0]     ad_data;
    logic           ad_otr;
    logic           arm;
    logic [7:0]     trig_level;
    logic           busy;
    logic           done;
    logic           otr_seen;
    logic           forced;
    logic [DL2-1:0] rd_addr;
    logic [7:0]     rd_data;

    int         checks = 0;
    int         failures = 0;
    logic [7:0] exp_q[$];
    bit         m_adclk = 1'b0;
    int         cyc = 0;

    always #10 clk = ~clk;

    ad_wave_capture #(
        .DEPTH_LOG2 (DL2),
        .TIMEOUT_SMP(TMO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ad_clk    (ad_clk),
        .ad_data   (ad_data),
        .ad_otr    (ad_otr),
        .arm       (arm),
        .trig_level(trig_level),
        .busy      (busy),
        .done      (done),
        .otr_seen  (otr_seen),
        .forced    (forced),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data)
    );

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cyc %0d)", tag, act, exp, cyc);
        end
    endtask

    // One clk: present sample data on strobe edges, junk otherwise.
    task automatic tick(input logic do_arm, input logic [7:0] sval, input logic sotr,
                        output bit was_smp);
        if (m_adclk) begin
            ad_data = sval;
            ad_otr  = sotr;
        end else begin
            ad_data = 8'($urandom);
            ad_otr  = 1'($urandom);
        end
        arm = do_arm;
        @(posedge clk);
        cyc++;
        was_smp = m_adclk;
        m_adclk = ~m_adclk;
        #1;
        arm = 1'b0;
        check_val("ad_clk", ad_clk, m_adclk);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_ad_clk"},   ad_clk,   0);
        check_val({tag, "_busy"},     busy,     0);
        check_val({tag, "_done"},     done,     0);
        check_val({tag, "_otr_seen"}, otr_seen, 0);
        check_val({tag, "_forced"},   forced,   0);
        check_val({tag, "_rd_data"},  rd_data,  0);
    endtask

    // Asynchronous reset pulse away from clock edges.
    task automatic pulse_reset(input string tag);
        rst = 1'b1;
        #2;
        check_reset_outputs(tag);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        m_adclk = 1'b0;
        exp_q.delete();
    endtask

    task automatic capture(input logic [7:0] level, input bit ramp, input logic [7:0] rstart,
                           input int otr_k, input int arm_k, input int rst_k,
                           input int hang_at, input string nm);
        logic [7:0] r;
        logic [7:0] prev;
        logic [7:0] v;
        bit         pv;
        bit         hit;
        bit         frc;
        bit         ws;
        bit         do_otr;
        bit         do_arm;
        bit         exp_otr;
        bit         exp_frc;
        int         k;
        int         cnt;
        int         tcyc;
        int         n_arm;
        r = rstart; prev = 8'h00; pv = 1'b0; k = 0; cnt = 0; tcyc = -1;
        exp_otr = 1'b0; exp_frc = 1'b0;
        exp_q.delete();
        trig_level = level;
        v = ramp ? r : 8'h90;
        tick(1'b1, v, 1'b0, ws);
        if (ws) r++;
        n_arm = cyc;
        check_val({nm, "_otr_clear_on_arm"}, otr_seen, 0);
        forever begin
            v = ramp ? r : 8'h90;
            do_otr = (tcyc >= 0) && (k == otr_k);
            do_arm = (tcyc >= 0) && (k == arm_k);
            tick(do_arm, v, do_otr, ws);
            if (cyc == n_arm + 1) begin
                check_val({nm, "_busy_after_arm"}, busy, 1);
                check_val({nm, "_done_after_arm"}, done, 0);
            end
            if (ws) begin
                r++;
                if (tcyc < 0) begin
                    cnt++;
                    hit = pv && (prev < level) && (v >= level);
                    frc = TMO_EN && !hit && (cnt == TMO);
                    if (hit || frc) begin
                        tcyc = cyc;
                        exp_q.push_back(v);
                        k = 1;
                        exp_frc = frc;
                    end else begin
                        prev = v;
                        pv = 1'b1;
                    end
                end else if (k < NREC) begin
                    exp_q.push_back(v);
                    exp_otr |= do_otr;
                    k++;
                end
            end
            if (tcyc >= 0 && rst_k >= 0 && k == rst_k) begin
                pulse_reset({nm, "_midrst"});
                return;
            end
            if (tcyc < 0 && hang_at > 0 && cyc - n_arm == hang_at) begin
                check_val({nm, "_hang_busy"}, busy, 1);
                check_val({nm, "_hang_done"}, done, 0);
                pulse_reset({nm, "_hangrst"});
                return;
            end
            if (tcyc < 0 && cyc - n_arm > 3000) begin
                check_val({nm, "_trigger_seen"}, 0, 1);
                pulse_reset({nm, "_bound"});
                return;
            end
            if (tcyc >= 0 && cyc == tcyc + 510) begin
                check_val({nm, "_done_early"}, done, 0);
                check_val({nm, "_busy_last"},  busy, 1);
            end
            if (tcyc >= 0 && cyc == tcyc + 511) begin
                check_val({nm, "_done"},     done,     1);
                check_val({nm, "_busy_end"}, busy,     0);
                check_val({nm, "_otr_seen"}, otr_seen, exp_otr);
                check_val({nm, "_forced"},   forced,   exp_frc);
                return;
            end
        end
    endtask

    // Back-to-back sweep; each rd_addr is answered one clk later.
    task automatic readback(input string nm);
        bit         ws;
        logic [7:0] e;
        for (int a = 0; a < int'(NREC); a++) begin
            rd_addr = DL2'(a);
            tick(1'b0, 8'h00, 1'b0, ws);
            if (exp_q.size() == 0) begin
                check_val({nm, "_rd_underflow"}, 1, 0);
            end else begin
                e = exp_q.pop_front();
                check_val({nm, "_rd_data"}, rd_data, e);
            end
        end
        check_val({nm, "_done_hold"}, done, 1);
    endtask

    initial begin
        rst = 1'b1;
        arm = 1'b0;
        ad_data = 8'h00;
        ad_otr = 1'b0;
        trig_level = 8'h00;
        rd_addr = '0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        rst = 1'b0;
        m_adclk = 1'b0;

        capture(8'h80, 1'b1, 8'h00, -1, -1, -1, 0, "ramp");
        readback("ramp");

        capture(8'h80, 1'b1, 8'h00, 100, 200, -1, 0, "otr_arm");
        readback("otr_arm");

        capture(8'h80, 1'b1, 8'h85, -1, -1, -1, 0, "rearm");
        readback("rearm");

        capture(8'h80, 1'b1, 8'h00, -1, -1, 50, 0, "abort");
        capture(8'h80, 1'b1, 8'h00, -1, -1, -1, 0, "post_rst");
        readback("post_rst");

        capture(8'h80, 1'b0, 8'h00, -1, -1, -1, TMO_EN ? 0 : 200, "const");
        if (TMO_EN) readback("const");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ad_wave_capture.md
# ad_wave_capture

Triggered capture engine for the AD9280 high-speed ADC path, the receive-side counterpart of the DA waveform sender. It generates the ADC sample clock from `clk`, samples `ad_data`, and waits for a rising-edge level trigger. It then stores a fixed-length record in an internal buffer. The buffer can be read back at leisure (UART dump, display, or loop-back comparison against the DA waveform ROM).

## Interface
- `DEPTH_LOG2`, 8: record length is 2^DEPTH_LOG2 samples; buffer address width.
- `TIMEOUT_SMP`, 1024: samples to wait in ARMED before forced trigger (only with `AD_CAP_TIMEOUT_EN`).
- `clk` in 1: system clock, 50 MHz.
- `rst` in 1: **reset is asynchronous and active-high**; one clock domain (`clk`).
- `ad_clk` out 1: AD9280 drive clock, `clk`/2 (25 MHz, under the 32 MHz max).
- `ad_data` in 8: ADC sample, unsigned offset binary.
- `ad_otr` in 1: ADC out-of-range flag.
- `arm` in 1: single-cycle start request.
- `trig_level` in 8: unsigned trigger threshold; sampled once when `arm` is accepted.
- `busy` out 1: high in ARMED and CAPTURE.
- `done` out 1: high in DONE; the record is valid.
- `otr_seen` out 1: sticky; set if `ad_otr` was high on any stored sample of the current record.
- `forced` out 1: the record was started by timeout, not by a level crossing.
- `rd_addr` in DEPTH_LOG2: buffer read address; 0 is the trigger sample.
- `rd_data` out 8: buffer word at `rd_addr`, registered.

## Operation
- Clock divider:
  - `ad_clk` is a register that toggles every `clk`.
  - The sample strobe `smp` is the `clk` cycle in which `ad_clk` is 1. The sample is registered at the edge that drives `ad_clk` low, which is mid data-valid window.
  - One sample every 2 `clk`. The divider runs free in all states.
- States: IDLE, ARMED, CAPTURE, DONE.
  - IDLE: if `arm` is high, latch `trig_level`, clear `prev_valid`, `otr_seen`, `forced` and the timeout counter, then go to ARMED.
  - ARMED: on each `smp`:
    - Trigger when `prev_valid && prev < level && ad_data >= level` (unsigned compare).
    - On trigger, write `ad_data` to address 0, set the write pointer to 1, and go to CAPTURE.
    - Otherwise store `prev = ad_data` and set `prev_valid`.
    - Because `prev_valid` starts clear, the first sample after arming can never trigger.
  - CAPTURE: on each `smp`, write `ad_data` at the write pointer and increment it. After the write to address 2^DEPTH_LOG2−1, go to DONE.
  - DONE: hold. If `arm` is high, re-enter ARMED with the same clears as from IDLE. `done` drops as ARMED is entered.
- `otr_seen` is ORed in on every buffer write, including the trigger sample.
- `arm` is ignored in ARMED and CAPTURE; there is no abort. Only `rst` stops a capture.
- Buffer: single-port-write / registered-read inferred RAM, 2^DEPTH_LOG2 × 8. The read port is active in every state. Contents are valid only while `done` is high; partial or stale data otherwise.
- Width rules:
  - Write pointer is DEPTH_LOG2 bits.
  - The terminal write is detected by pointer == all-ones, not by wrap.
  - The timeout counter is clog2(TIMEOUT_SMP+1) bits and saturates.

## Timing
- Reset values: `ad_clk`=0, `busy`=0, `done`=0, `otr_seen`=0, `forced`=0, `rd_data`=0, state IDLE. Buffer contents are not cleared.
- `arm` high at edge N: `busy`=1 from N+1.
- Trigger on `smp` at edge T: the trigger sample is stored at T, and samples k=1..255 are stored at T+2k.
- The last write is at T+510. `done`=1 and `busy`=0 from T+511 (one `clk` after the last write).
- `rd_data` = buf[`rd_addr`] one `clk` after `rd_addr` is presented.
- `rst` asserted mid-capture: all outputs return to reset values immediately (async). Restart requires a new `arm`.
- `arm` coincident with `smp` in IDLE: that sample is not evaluated. Evaluation starts at the next `smp`.

## Configuration
- `AD_CAP_TIMEOUT_EN` defined:
  - In ARMED, count `smp`s. When the count reaches TIMEOUT_SMP without a trigger, force a trigger on that sample.
  - Store the sample at address 0, set `forced`=1, and continue as a normal CAPTURE.
- Not defined: the counter and `forced` logic are absent, and `forced` is tied to 0. ARMED waits indefinitely.

## Test plan
- Ramp 0..255 repeating, `trig_level`=0x80, `arm` pulse:
  - buf[0]=0x80, buf[k]=(0x80+k) mod 256.
  - `done` 511 `clk` after the trigger edge; `otr_seen`=0, `forced`=0.
- `ad_data` constant 0x90 at arm with `trig_level`=0x80 (already above, no rising crossing): no trigger, `busy` stays 1. With `AD_CAP_TIMEOUT_EN` and TIMEOUT_SMP=16: trigger on the 16th sample, all buf=0x90, `forced`=1.
- `ad_otr` pulsed for one `smp` during CAPTURE at sample 100: `otr_seen`=1 at `done`. Re-arm: `otr_seen` clears on entering ARMED.
- `rst` pulsed at sample 50 of CAPTURE:
  - All outputs are 0 within the reset cycle.
  - Re-arm with a ramp: a full valid record is captured and `done` asserts normally.
- `arm` pulsed during CAPTURE: ignored; `done` timing unchanged.
- After `done`, sweep `rd_addr` 0..255 back-to-back: `rd_data` matches the expected buf with 1-cycle latency.
- `ad_clk` checked throughout: period 2 `clk`, 50 % duty cycle, free-running in all states.
